ctrl_decode_pipe: RTL and testbench

Registered, parametrised successor to the combinational opcode control decoder. Each fetched instruction (opcode, op_ext, pc) is decoded into a packed control word and buffered in a 2-entry elastic queue with valid/ready handshakes on both sides. A halt state machine drains the stage before asserting `halted`. Branch flags are decoded distinctly (BEQZ/BNEZ/BLTZ/BGEZ). Sits between fetch and execute in the single-issue core.

---
 rtl/ctrl_pkg.sv | 76 +++++++
 rtl/ctrl_decode.sv | 99 +++++++++
 rtl/ctrl_decode_pipe.sv | 133 +++++++++++++
 tb/tb_ctrl_decode_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
`default_nettype none
//============================================================================
// Module   : ctrl_pkg
// Brief    : Shared opcode map, control-word layout and halt FSM encoding for
//            the registered decode stage.
// Revision : 1.0 - initial release
//============================================================================
package ctrl_pkg;

    // Control word width; bit 28 is a reserved pad that always reads 0
    localparam int CTRL_W = 29;

    // Opcode map (low five opcode bits)
    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_NOP  = 5'b00001;
    localparam logic [4:0] OP_BEQZ = 5'b01100;
    localparam logic [4:0] OP_BNEZ = 5'b01101;
    localparam logic [4:0] OP_BLTZ = 5'b01110;
    localparam logic [4:0] OP_BGEZ = 5'b01111;
    localparam logic [4:0] OP_ST   = 5'b10000;
    localparam logic [4:0] OP_LD   = 5'b10001;
    localparam logic [4:0] OP_ALU  = 5'b11011;

    // R-type function select carried in op_ext
    localparam logic [1:0] EXT_ADD  = 2'b00;
    localparam logic [1:0] EXT_SUB  = 2'b01;
    localparam logic [1:0] EXT_XOR  = 2'b10;
    localparam logic [1:0] EXT_ANDN = 2'b11;

    // ALU core operation
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_XOR = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;

    // Operand / destination selects
    localparam logic [1:0] SEL_DST_NONE = 2'd0;
    localparam logic [1:0] SEL_DST_RT   = 2'd1;
    localparam logic [1:0] SEL_DST_RD   = 2'd2;
    localparam logic [1:0] SEL_B_REG    = 2'd0;
    localparam logic [1:0] SEL_B_IMM    = 2'd1;

    // Packed control word; first member is the MSB, so fields read MSB->LSB
    typedef struct packed {
        logic       rsvd;
        logic       illegal;
        logic       halt;
        logic       sel_wb;
        logic       mem_write;
        logic       mem_read;
        logic       sign;
        logic       inv_b;
        logic       inv_a;
        logic       cin;
        logic       jump;
        logic       bgez;
        logic       bltz;
        logic       bnez;
        logic       beqz;
        logic       sel_pc_opB;
        logic       sel_pc_opA;
        logic       reg_write;
        logic [3:0] alu_op_ext;
        logic [2:0] alu_op;
        logic [1:0] sel_alu_opB;
        logic [1:0] sel_reg_dst;
    } ctrl_t;

    // Halt sequencing states
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
//============================================================================
// Module   : ctrl_decode
// Brief    : Combinational opcode/op_ext to control-word decoder.
// Revision : 1.0 - initial release
//============================================================================
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 5,
    parameter int EXT_W    = 2
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [EXT_W-1:0]    op_ext,
    output ctrl_t               ctrl
);

    logic [4:0] op_low;
    logic       upper_nz;
    logic [3:0] ext_wide;
    logic       is_legal;

    assign op_low   = opcode[4:0];
    assign ext_wide = 4'(op_ext);

    // Any set opcode bit above the five-bit map makes the word illegal
    generate
        if (OPCODE_W > 5) begin : g_upper
            assign upper_nz = |opcode[OPCODE_W-1:5];
        end else begin : g_no_upper
            assign upper_nz = 1'b0;
        end
    endgenerate

    // Decode the opcode map; illegal words collapse to a lone illegal flag
    always_comb begin
        ctrl     = '0;
        is_legal = 1'b1;
        case (op_low)
            OP_HALT: ctrl.halt = 1'b1;
            OP_NOP:  ;
            OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ: begin
                ctrl.sel_pc_opA = 1'b1;
                ctrl.sel_pc_opB = 1'b1;
                ctrl.beqz       = (op_low == OP_BEQZ);
                ctrl.bnez       = (op_low == OP_BNEZ);
                ctrl.bltz       = (op_low == OP_BLTZ);
                ctrl.bgez       = (op_low == OP_BGEZ);
            end
            OP_ST: begin
                ctrl.sel_alu_opB = SEL_B_IMM;
                ctrl.alu_op      = ALU_ADD;
                ctrl.mem_write   = 1'b1;
            end
            OP_LD: begin
                ctrl.sel_reg_dst = SEL_DST_RT;
                ctrl.sel_alu_opB = SEL_B_IMM;
                ctrl.alu_op      = ALU_ADD;
                ctrl.mem_read    = 1'b1;
                ctrl.sel_wb      = 1'b1;
                ctrl.reg_write   = 1'b1;
            end
            OP_ALU: begin
                ctrl.sel_reg_dst = SEL_DST_RD;
                ctrl.sel_alu_opB = SEL_B_REG;
                ctrl.alu_op_ext  = ext_wide;
                ctrl.reg_write   = 1'b1;
                case (op_ext[1:0])
                    EXT_ADD:  ctrl.alu_op = ALU_ADD;
                    EXT_SUB: begin
                        ctrl.alu_op = ALU_ADD;
                        ctrl.inv_b  = 1'b1;
                        ctrl.cin    = 1'b1;
                    end
                    EXT_XOR:  ctrl.alu_op = ALU_XOR;
                    default: begin
                        ctrl.alu_op = ALU_AND;
                        ctrl.inv_b  = 1'b1;
                    end
                endcase
            end
            default: is_legal = 1'b0;
        endcase

        if (upper_nz) begin
            is_legal = 1'b0;
        end

        // NOP stays all-zero; every other legal word is a signed operation
        if (!is_legal) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
        end else if (op_low != OP_NOP) begin
            ctrl.sign = 1'b1;
        end
    end

endmodule : ctrl_decode
`default_nettype wire

// File: rtl/ctrl_decode_pipe.sv
`default_nettype none
//============================================================================
// Module   : ctrl_decode_pipe
// Brief    : Registered decode stage: decoder feeding a 2-entry elastic queue
//            with valid/ready on both sides and a halt drain state machine.
// Revision : 1.0 - initial release
//============================================================================
module ctrl_decode_pipe
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 5,
    parameter int EXT_W    = 2,
    parameter int PC_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPCODE_W-1:0] in_opcode,
    input  logic [EXT_W-1:0]    in_op_ext,
    input  logic [PC_W-1:0]     in_pc,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CTRL_W-1:0]   out_ctrl,
    output logic [PC_W-1:0]     out_pc,
    output logic                halted,
    output logic                err_illegal
);

    ctrl_t           dec_ctrl;
    ctrl_t           ctrl_mem [2];
    logic [PC_W-1:0] pc_mem   [2];
    ctrl_t           head_ctrl;
    logic            rd_ptr;
    logic            wr_ptr;
    logic [1:0]      count;
    state_t          state;
    state_t          state_nxt;
    logic            flush_eff;
    logic            push;
    logic            pop;
    logic            err_q;

    ctrl_decode #(
        .OPCODE_W (OPCODE_W),
        .EXT_W    (EXT_W)
    ) u_decode (
        .opcode (in_opcode),
        .op_ext (in_op_ext),
        .ctrl   (dec_ctrl)
    );

    // Handshake qualifiers; in_ready sees only registered state
    assign flush_eff = flush && (state != ST_HALTED);
    assign in_ready  = (state == ST_RUN) && (count != 2'd2);
    assign out_valid = (state != ST_HALTED) && (count != 2'd0);
    assign push      = in_valid && in_ready && !flush_eff;
    assign pop       = out_valid && out_ready;

    assign head_ctrl   = ctrl_mem[rd_ptr];
    assign out_ctrl    = head_ctrl;
    assign out_pc      = pc_mem[rd_ptr];
    assign halted      = (state == ST_HALTED);
    assign err_illegal = err_q;

    // Two-entry FIFO storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_mem[0] <= '0;
            ctrl_mem[1] <= '0;
            pc_mem[0]   <= '0;
            pc_mem[1]   <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (push) begin
                ctrl_mem[wr_ptr] <= dec_ctrl;
                pc_mem[wr_ptr]   <= in_pc;
            end
            if (flush_eff) begin
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
                count  <= 2'd0;
            end else begin
                if (push) wr_ptr <= ~wr_ptr;
                if (pop)  rd_ptr <= ~rd_ptr;
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Halt FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Halt FSM next state; a flush while draining squashes the pending halt
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (push && dec_ctrl.halt) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (flush_eff)                   state_nxt = ST_RUN;
                else if (pop && head_ctrl.halt)  state_nxt = ST_HALTED;
            end
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_RUN;
        endcase
    end

    // Sticky illegal-opcode flag, set only by words actually accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (push && dec_ctrl.illegal) begin
            err_q <= 1'b1;
        end
    end

endmodule : ctrl_decode_pipe
`default_nettype wire

// File: tb/tb_ctrl_decode_pipe.sv
`default_nettype none
//============================================================================
// Module   : tb_ctrl_decode_pipe
// Brief    : Scoreboard bench for the registered decode stage.
// Revision : 1.0 - initial release
//============================================================================
module tb_ctrl_decode_pipe;

    localparam int CW = 29;

    // Control-word bit positions
    localparam int B_REG_WRITE = 11;
    localparam int B_BEQZ      = 14;
    localparam int B_BNEZ      = 15;
    localparam int B_BLTZ      = 16;
    localparam int B_BGEZ      = 17;
    localparam int B_CIN       = 19;
    localparam int B_INV_B     = 21;
    localparam int B_SIGN      = 22;
    localparam int B_MEM_READ  = 23;
    localparam int B_MEM_WRITE = 24;
    localparam int B_SEL_WB    = 25;
    localparam int B_HALT      = 26;
    localparam int B_ILLEGAL   = 27;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_opcode;
    logic [1:0]    in_op_ext;
    logic [15:0]   in_pc;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [15:0]   out_pc;
    logic          halted;
    logic          err_illegal;

    typedef struct {
        logic [CW-1:0] exp;
        logic [CW-1:0] mask;
        logic [15:0]   pc;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    ctrl_decode_pipe #(
        .OPCODE_W (5),
        .EXT_W    (2),
        .PC_W     (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_op_ext   (in_op_ext),
        .in_pc       (in_pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ctrl    (out_ctrl),
        .out_pc      (out_pc),
        .halted      (halted),
        .err_illegal (err_illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] b(input int i);
        logic [CW-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Fields every check looks at
    function automatic logic [CW-1:0] m_core();
        return b(B_REG_WRITE) | b(B_BEQZ) | b(B_BNEZ) | b(B_BLTZ) | b(B_BGEZ) |
               b(B_CIN) | b(B_INV_B) | b(B_SIGN) | b(B_MEM_READ) |
               b(B_MEM_WRITE) | b(B_SEL_WB) | b(B_HALT) | b(B_ILLEGAL);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    endtask

    // Monitor: pop and compare on every output transfer
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_output: actual pc 0x%0h required no transfer", out_pc);
                end else begin
                    e = sb.pop_front();
                    check("out_ctrl", 32'(out_ctrl & e.mask), 32'(e.exp));
                    check("out_pc", 32'(out_pc), 32'(e.pc));
                end
            end
        end
    end

    // Present one word and hold it until accepted (bounded)
    task automatic push(input logic [4:0] op, input logic [1:0] ext, input logic [15:0] pc,
                        input logic [CW-1:0] e, input logic [CW-1:0] m);
        logic acc;
        exp_t r;
        in_valid  = 1'b1;
        in_opcode = op;
        in_op_ext = ext;
        in_pc     = pc;
        acc       = 1'b0;
        for (int k = 0; k < 40 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (acc) begin
            r.exp  = e;
            r.mask = m;
            r.pc   = pc;
            sb.push_back(r);
        end else begin
            n_total++;
            $display("FAIL push_timeout: actual in_ready 0 required 1 (pc 0x%0h)", pc);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
        #1;
        check(name, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] mc;
        mc        = m_core();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_opcode = '0;
        in_op_ext = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_err", 32'(err_illegal), 0);
        check("rst_out_ctrl", 32'(out_ctrl), 0);
        check("rst_out_pc", 32'(out_pc), 0);
        check("rst_in_ready", 32'(in_ready), 1);

        // Streaming decode, out_ready held high
        out_ready = 1'b1;
        push(5'b11011, 2'b00, 16'h0010, b(B_REG_WRITE) | b(B_SIGN), mc);
        check("latency_out_valid", 32'(out_valid), 1);
        push(5'b11011, 2'b01, 16'h0011, b(B_REG_WRITE) | b(B_SIGN) | b(B_INV_B) | b(B_CIN), mc);
        push(5'b11011, 2'b10, 16'h0012, b(B_REG_WRITE) | b(B_SIGN), mc);
        push(5'b11011, 2'b11, 16'h0013, b(B_REG_WRITE) | b(B_SIGN) | b(B_INV_B), mc);
        push(5'b01100, 2'b00, 16'h0020, b(B_BEQZ) | b(B_SIGN), mc);
        push(5'b01101, 2'b00, 16'h0021, b(B_BNEZ) | b(B_SIGN), mc);
        push(5'b01110, 2'b00, 16'h0022, b(B_BLTZ) | b(B_SIGN), mc);
        push(5'b01111, 2'b00, 16'h0023, b(B_BGEZ) | b(B_SIGN), mc);
        push(5'b10001, 2'b00, 16'h0030, b(B_MEM_READ) | b(B_SEL_WB) | b(B_REG_WRITE) | b(B_SIGN), mc);
        push(5'b10000, 2'b00, 16'h0031, b(B_MEM_WRITE) | b(B_SIGN), mc);
        push(5'b00001, 2'b00, 16'h0032, '0, mc & ~b(B_SIGN));
        wait_drain("drain_stream");

        // Backpressure: fill, hold, release
        out_ready = 1'b0;
        push(5'b11011, 2'b00, 16'h0040, b(B_REG_WRITE) | b(B_SIGN), mc);
        push(5'b11011, 2'b01, 16'h0041, b(B_REG_WRITE) | b(B_SIGN) | b(B_INV_B) | b(B_CIN), mc);
        check("full_in_ready", 32'(in_ready), 0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_out_valid", 32'(out_valid), 1);
        check("hold_out_pc", 32'(out_pc), 32'h0040);
        out_ready = 1'b1;
        push(5'b11011, 2'b10, 16'h0042, b(B_REG_WRITE) | b(B_SIGN), mc);
        wait_drain("drain_backpressure");

        // Illegal opcode and sticky error
        push(5'b10101, 2'b00, 16'h0050, b(B_ILLEGAL), '1);
        check("err_set", 32'(err_illegal), 1);
        push(5'b11011, 2'b00, 16'h0051, b(B_REG_WRITE) | b(B_SIGN), mc);
        wait_drain("drain_illegal");
        check("err_sticky", 32'(err_illegal), 1);

        // Flush while draining with both entries full
        out_ready = 1'b0;
        push(5'b10001, 2'b00, 16'h0060, b(B_MEM_READ) | b(B_SEL_WB) | b(B_REG_WRITE) | b(B_SIGN), mc);
        push(5'b00000, 2'b00, 16'h0061, b(B_HALT), mc & ~b(B_SIGN));
        check("drain_in_ready", 32'(in_ready), 0);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_opcode = 5'b11011;
        in_op_ext = 2'b00;
        in_pc     = 16'h0062;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        check("flush_out_valid", 32'(out_valid), 0);
        check("flush_run_in_ready", 32'(in_ready), 1);
        check("flush_halted", 32'(halted), 0);
        out_ready = 1'b1;
        push(5'b11011, 2'b11, 16'h0063, b(B_REG_WRITE) | b(B_SIGN) | b(B_INV_B), mc);
        wait_drain("drain_after_flush");

        // Halt sequence
        out_ready = 1'b0;
        push(5'b00000, 2'b00, 16'h0070, b(B_HALT), mc & ~b(B_SIGN));
        check("halt_in_ready", 32'(in_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        check("halt_pending", 32'(halted), 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("halted_rise", 32'(halted), 1);
        check("halted_out_valid", 32'(out_valid), 0);
        check("halt_consumed", 32'(sb.size()), 0);
        in_valid  = 1'b1;
        in_opcode = 5'b11011;
        in_pc     = 16'h0071;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("halted_in_ready", 32'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("halted_stays", 32'(halted), 1);

        // Reset clears halt and the sticky error
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("rerst_halted", 32'(halted), 0);
        check("rerst_err", 32'(err_illegal), 0);
        check("rerst_in_ready", 32'(in_ready), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_ctrl_decode_pipe
`default_nettype wire
